fetch_ctrl: RTL

Pipeline sequencer for the fetch stage. It drives the PC write enable, the PC-source mux select, and the IF/ID enable and flush, plus the ID/EX flush. It arbitrates between three conditions: a taken branch/jump resolved in EX, a load-use stall from decode, and a halt (ecall/ebreak) from decode. It also enforces a post-reset hold window before fetch starts and supports halt/resume for debug.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, IF/ID enable/flush and ID/EX flush.
// Outputs are Mealy (registered state plus current inputs), so the control path adds no latency.
// Priority is redirect > halt > stall. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module fetch_ctrl #(
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src_ex,
    input  logic             stall_req_d,
    input  logic             halt_req_d,
    input  logic             resume,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [2:0]       state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic       redirect_acc;
    logic       stall_acc;

    // State register and post-reset hold counter; the counter only runs while in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_HOLD;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 8'd1 : 8'd0;
        end
    end

    // Next-state and Mealy outputs; STALL behaves like RUN except the stall request is masked.
    always_comb begin
        state_nxt    = state;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        redirect_acc = 1'b0;
        stall_acc    = 1'b0;
        case (state)
            S_HOLD: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN, S_STALL: begin
                pc_we     = 1'b1;
                ifid_we   = 1'b1;
                state_nxt = S_RUN;
                if (pc_src_ex) begin
                    pc_sel       = 1'b1;
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    redirect_acc = 1'b1;
                    state_nxt    = S_FLUSH;
                end else if (halt_req_d) begin
                    // Halt instruction moves on to EX; the PC stays at halt+1.
                    pc_we      = 1'b0;
                    ifid_flush = 1'b1;
                    state_nxt  = S_HALT;
                end else if (stall_req_d && (state == S_RUN)) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    stall_acc  = 1'b1;
                    state_nxt  = S_STALL;
                end
            end
            S_FLUSH: begin
                // ID and EX only hold bubbles here, so every request is stale.
                pc_we     = 1'b1;
                ifid_we   = 1'b1;
                state_nxt = S_RUN;
            end
            S_HALT: begin
                if (resume) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_nxt  = S_HOLD;
            end
        endcase
    end

    assign halted  = (state == S_HALT);
    assign state_o = state;

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of accepted stalls and accepted redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_acc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect_acc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    // Acceptance strobes only feed the perf counters.
    logic unused_acc;
    assign unused_acc = redirect_acc ^ stall_acc;
`endif

endmodule
